// File: rtl/dmem_lsu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_lsu : RV32I load/store initiator between core MEM stage and dmem bus
// Rev 1.0
// ---------------------------------------------------------------------------
module dmem_lsu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_we_i,
  input  logic [2:0]         req_funct3_i,
  input  logic [WIDTH-1:0]   req_addr_i,
  input  logic [WIDTH-1:0]   req_wdata_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [WIDTH-1:0]   rsp_rdata_o,
  output logic               rsp_err_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic [WIDTH-3:0]   mem_addr_o,
  output logic [WIDTH-1:0]   mem_wdata_o,
  output logic [3:0]         mem_byteen_o,
  input  logic [WIDTH-1:0]   mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e             state_q;
  logic               we_q;
  logic [2:0]         funct3_q;
  logic [1:0]         lane_q;
  logic               req_ready_q;
  logic               rsp_valid_q;
  logic               rsp_err_q;
  logic [WIDTH-1:0]   rsp_rdata_q;
  logic               mem_read_q;
  logic               mem_write_q;
  logic [WIDTH-3:0]   mem_addr_q;
  logic [WIDTH-1:0]   mem_wdata_q;
  logic [3:0]         mem_byteen_q;

  logic               req_ok_d;
  logic [3:0]         byteen_d;
  logic [WIDTH-1:0]   wdata_d;
  logic [WIDTH-1:0]   load_d;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;

  // Request decode: legality, alignment, lane enables and lane-replicated data
  always_comb begin
    req_ok_d = 1'b0;
    byteen_d = 4'b0000;
    wdata_d  = '0;
    case (req_funct3_i)
      3'b000: begin
        req_ok_d = 1'b1;
        byteen_d = 4'b0001 << req_addr_i[1:0];
        wdata_d  = {4{req_wdata_i[7:0]}};
      end
      3'b001: begin
        req_ok_d = ~req_addr_i[0];
        byteen_d = 4'b0011 << req_addr_i[1:0];
        wdata_d  = {2{req_wdata_i[15:0]}};
      end
      3'b010: begin
        req_ok_d = (req_addr_i[1:0] == 2'b00);
        byteen_d = 4'b1111;
        wdata_d  = req_wdata_i;
      end
      3'b100: begin
        req_ok_d = ~req_we_i;
        byteen_d = 4'b0001 << req_addr_i[1:0];
      end
      3'b101: begin
        req_ok_d = ~req_we_i & ~req_addr_i[0];
        byteen_d = 4'b0011 << req_addr_i[1:0];
      end
      default: req_ok_d = 1'b0;
    endcase
  end

  // Lane extraction of the word returned during ACCESS
  always_comb begin
    ld_byte = mem_rdata_i[7:0];
    case (lane_q)
      2'd0:    ld_byte = mem_rdata_i[7:0];
      2'd1:    ld_byte = mem_rdata_i[15:8];
      2'd2:    ld_byte = mem_rdata_i[23:16];
      default: ld_byte = mem_rdata_i[31:24];
    endcase
    ld_half = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    load_d  = mem_rdata_i;
    case (funct3_q)
      3'b000:  load_d = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_d = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_d = {24'h0, ld_byte};
      3'b101:  load_d = {16'h0, ld_half};
      default: load_d = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      lane_q       <= 2'b00;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_byteen_q <= 4'b0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            we_q        <= req_we_i;
            funct3_q    <= req_funct3_i;
            lane_q      <= req_addr_i[1:0];
            req_ready_q <= 1'b0;
            if (req_ok_d) begin
              state_q      <= S_ACCESS;
              mem_addr_q   <= req_addr_i[WIDTH-1:2];
              mem_byteen_q <= byteen_d;
              mem_write_q  <= req_we_i;
              mem_read_q   <= ~req_we_i;
              mem_wdata_q  <= req_we_i ? wdata_d : '0;
            end else begin
              // Rejected requests never touch the bus
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end
          end
        end
        S_ACCESS: begin
          state_q      <= S_RESP;
          mem_read_q   <= 1'b0;
          mem_write_q  <= 1'b0;
          mem_addr_q   <= '0;
          mem_wdata_q  <= '0;
          mem_byteen_q <= 4'b0000;
          rsp_valid_q  <= 1'b1;
          rsp_err_q    <= 1'b0;
          rsp_rdata_q  <= we_q ? '0 : load_d;
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_err_o    = rsp_err_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_byteen_o = mem_byteen_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_lsu : scoreboard bench for dmem_lsu with a 16-word dmem model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_read, mem_write;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_byteen;
  logic        mem_init;

  logic [31:0] mem    [16];
  logic [31:0] shadow [16];
  logic [32:0] sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.WIDTH(32)) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .mem_read_o   (mem_read),
    .mem_write_o  (mem_write),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_byteen_o (mem_byteen),
    .mem_rdata_i  (mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'h80FF_7F01 : (32'h1357_9BDF ^ (32'h0101_0101 * i));
  endfunction

  assign mem_rdata = mem[mem_addr[3:0]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    end else if (mem_write) begin
      for (int b = 0; b < 4; b++)
        if (mem_byteen[b]) mem[mem_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic ref_ok(input logic we, input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000:  return 1'b1;
      3'b001:  return a[0] == 1'b0;
      3'b010:  return a[1:0] == 2'b00;
      3'b100:  return !we;
      3'b101:  return !we && (a[0] == 1'b0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] ref_byteen(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000, 3'b100: return (a[1:0] == 2'd0) ? 4'b0001 : (a[1:0] == 2'd1) ? 4'b0010 :
                             (a[1:0] == 2'd2) ? 4'b0100 : 4'b1000;
      3'b001, 3'b101: return a[1] ? 4'b1100 : 4'b0011;
      default:        return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {d[7:0], d[7:0], d[7:0], d[7:0]};
      3'b001:  return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = shadow[a[5:2]];
    b = w[8*a[1:0] +: 8];
    h = w[16*a[1] +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int hold);
    logic        ok;
    logic [32:0] e;
    logic [31:0] snap;
    logic [3:0]  be;
    int          cyc;
    @(negedge clk);
    check_eq("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    ok = ref_ok(we, f3, a);
    if (!ok)     e = {1'b1, 32'h0};
    else if (we) e = 33'h0;
    else         e = {1'b0, ref_load(f3, a)};
    sb_q.push_back(e);
    if (ok && we) begin
      be = ref_byteen(f3, a);
      for (int b = 0; b < 4; b++)
        if (be[b]) shadow[a[5:2]][8*b +: 8] = ref_wdata(f3, d) >> (8*b);
    end
    @(negedge clk);
    req_valid = 1'b0;
    if (ok) begin
      check_eq("mem_write", mem_write, we);
      check_eq("mem_read", mem_read, !we);
      check_eq("mem_addr", mem_addr, a[31:2]);
      check_eq("mem_byteen", mem_byteen, ref_byteen(f3, a));
      check_eq("mem_wdata", mem_wdata, we ? ref_wdata(f3, d) : 32'h0);
      check_eq("rsp_valid_access", rsp_valid, 0);
    end else begin
      check_eq("err_no_strobe", {mem_read, mem_write, mem_byteen}, 0);
    end
    cyc = 0;
    while (!rsp_valid && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("rsp_latency", cyc, ok ? 1 : 0);
    check_eq("bus_idle_resp", {mem_read, mem_write, mem_byteen, mem_wdata}, 0);
    snap = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h0000_0000; req_wdata = $urandom;
      @(negedge clk);
      check_eq("hold_valid", rsp_valid, 1);
      check_eq("hold_rdata", rsp_rdata, snap);
      check_eq("hold_req_ready", req_ready, 0);
      check_eq("hold_no_bus", {mem_read, mem_write}, 0);
    end
    if (sb_q.size() != 0) e = sb_q.pop_front();
    check_eq("rsp_rdata", rsp_rdata, e[31:0]);
    check_eq("rsp_err", rsp_err, e[32]);
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("rsp_done_valid", rsp_valid, 0);
    check_eq("rsp_done_ready", req_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) shadow[i] = init_word(i);
    rst_n = 1'b0; mem_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    check_eq("rst_bus", {mem_read, mem_write, mem_addr, mem_wdata, mem_byteen}, 0);
    rst_n = 1'b1; mem_init = 1'b0;

    do_req(1'b0, 3'b000, 32'h13, 32'h0, 0);
    do_req(1'b0, 3'b100, 32'h13, 32'h0, 0);
    do_req(1'b0, 3'b000, 32'h11, 32'h0, 0);
    do_req(1'b0, 3'b001, 32'h12, 32'h0, 0);
    do_req(1'b0, 3'b101, 32'h12, 32'h0, 0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 5);
    do_req(1'b1, 3'b001, 32'h11, 32'h1234, 0);
    do_req(1'b0, 3'b011, 32'h10, 32'h0, 0);
    do_req(1'b1, 3'b100, 32'h10, 32'h55, 0);
    do_req(1'b0, 3'b010, 32'h12, 32'h0, 0);
    do_req(1'b1, 3'b000, 32'h12, 32'hAB, 0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 0);
    do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 0);
    do_req(1'b1, 3'b001, 32'h1A, 32'hCAFE_1234, 0);
    do_req(1'b0, 3'b001, 32'h1A, 32'h0, 2);
    for (int i = 0; i < 24; i++)
      do_req(1'(($urandom_range(0, 1))), 3'($urandom_range(0, 7)),
             32'($urandom_range(0, 63)), $urandom, 0);

    // Reset during the ACCESS cycle of a store: nothing commits, no response
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h24; req_wdata = 32'h5555_AAAA;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("rst_mid_write_pre", mem_write, 1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_write_drop", mem_write, 0);
    check_eq("rst_mid_rsp", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_req_ready", req_ready, 1);
    check_eq("rst_mid_no_rsp", rsp_valid, 0);

    for (int i = 0; i < 16; i++) check_eq("mem_word", mem[i], shadow[i]);
    check_eq("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
